// File: rtl/note_draw_arbiter_if.sv
// note_draw_arbiter_if
// Bundles every non-clock/reset signal of the note-draw sequencer:
//   req0_* / req1_*  draw requests (valid/ready, note type, glyph x/y)
//   rom_*            glyph ROM select, row address and row data
//   fb_*             framebuffer row write port with fb_ready backpressure
//   done_*           one-cycle completion pulse with requester id and error
// Modport slave is the sequencer side; modport master is the environment
// side (score logic, ROM and framebuffer).

`ifndef QUARTER_NOTE
`define QUARTER_NOTE 2'd0
`endif
`ifndef HALF_NOTE
`define HALF_NOTE 2'd1
`endif
`ifndef WHOLE_NOTE
`define WHOLE_NOTE 2'd2
`endif
`ifndef NOTE_WIDTH
`define NOTE_WIDTH 28
`endif

interface note_draw_arbiter_if #(
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int NOTE_WIDTH = `NOTE_WIDTH
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [1:0]            req0_type;
    logic [X_W-1:0]        req0_x;
    logic [Y_W-1:0]        req0_y;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [1:0]            req1_type;
    logic [X_W-1:0]        req1_x;
    logic [Y_W-1:0]        req1_y;

    logic [1:0]            rom_type;
    logic [4:0]            rom_addr;
    logic [NOTE_WIDTH-1:0] rom_data;

    logic                  fb_we;
    logic [X_W-1:0]        fb_x;
    logic [Y_W-1:0]        fb_y;
    logic [NOTE_WIDTH-1:0] fb_data;
    logic                  fb_ready;

    logic                  done_valid;
    logic                  done_id;
    logic                  done_err;

    modport slave (
        input  req0_valid, req0_type, req0_x, req0_y,
        output req0_ready,
        input  req1_valid, req1_type, req1_x, req1_y,
        output req1_ready,
        output rom_type, rom_addr,
        input  rom_data,
        output fb_we, fb_x, fb_y, fb_data,
        input  fb_ready,
        output done_valid, done_id, done_err
    );

    modport master (
        output req0_valid, req0_type, req0_x, req0_y,
        input  req0_ready,
        output req1_valid, req1_type, req1_x, req1_y,
        input  req1_ready,
        input  rom_type, rom_addr,
        output rom_data,
        input  fb_we, fb_x, fb_y, fb_data,
        output fb_ready,
        input  done_valid, done_id, done_err
    );
endinterface

// File: rtl/note_draw_arbiter.sv
// note_draw_arbiter
// Round-robin arbiter between two note-draw requesters (0: score playback,
// 1: cursor/preview) followed by a row walker over the glyph ROM. Each ROM
// row goes straight (combinationally) to the framebuffer write port; a row
// only advances when the framebuffer accepts it.
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset; also forces every output low
//   bus    note_draw_arbiter_if.slave (requests, ROM, framebuffer, done)

`ifndef QUARTER_NOTE
`define QUARTER_NOTE 2'd0
`endif
`ifndef HALF_NOTE
`define HALF_NOTE 2'd1
`endif
`ifndef WHOLE_NOTE
`define WHOLE_NOTE 2'd2
`endif
`ifndef NOTE_WIDTH
`define NOTE_WIDTH 28
`endif

module note_draw_arbiter #(
    parameter int ROWS = 24,
    parameter int X_W  = 10,
    parameter int Y_W  = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    note_draw_arbiter_if.slave     bus
);
    localparam int NW = `NOTE_WIDTH;
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t          state_reg, state_next;
    logic [4:0]      row_reg, row_next;
    logic            last_grant_reg, last_grant_next;
    logic [1:0]      type_reg, type_next;
    logic [X_W-1:0]  x_reg, x_next;
    logic [Y_W-1:0]  y_reg, y_next;
    logic            id_reg, id_next;
    logic            err_reg, err_next;

    // Requests gathered into indexable form so the arbiter is written once.
    logic [1:0]      req_valid;
    logic [1:0]      grant;
    logic [1:0]      req_type_arr [2];
    logic [X_W-1:0]  req_x_arr    [2];
    logic [Y_W-1:0]  req_y_arr    [2];

    assign req_valid       = {bus.req1_valid, bus.req0_valid};
    assign req_type_arr[0] = bus.req0_type;
    assign req_type_arr[1] = bus.req1_type;
    assign req_x_arr[0]    = bus.req0_x;
    assign req_x_arr[1]    = bus.req1_x;
    assign req_y_arr[0]    = bus.req0_y;
    assign req_y_arr[1]    = bus.req1_y;

    // A requester wins when it is alone, or when both contend and it was
    // not the previous winner. The loser keeps valid high and wins next.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req_valid[gi] &&
                               (!req_valid[1-gi] || (last_grant_reg != 1'(gi)));
        end
    endgenerate

    logic            sel;
    logic [1:0]      sel_type;
    logic            sel_is_note;

    assign sel         = grant[1];
    assign sel_type    = req_type_arr[sel];
    assign sel_is_note = (sel_type == `QUARTER_NOTE) ||
                         (sel_type == `HALF_NOTE)    ||
                         (sel_type == `WHOLE_NOTE);

    // Output values before the reset mask.
    logic [1:0]      ready_vec;
    logic [1:0]      rom_type_c;
    logic [4:0]      rom_addr_c;
    logic            fb_we_c;
    logic [X_W-1:0]  fb_x_c;
    logic [Y_W-1:0]  fb_y_c;
    logic [NW-1:0]   fb_data_c;
    logic            done_valid_c;
    logic            done_id_c;
    logic            done_err_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            row_reg        <= '0;
            last_grant_reg <= 1'b1;
            type_reg       <= '0;
            x_reg          <= '0;
            y_reg          <= '0;
            id_reg         <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            last_grant_reg <= last_grant_next;
            type_reg       <= type_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            id_reg         <= id_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        row_next        = row_reg;
        last_grant_next = last_grant_reg;
        type_next       = type_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        id_next         = id_reg;
        err_next        = err_reg;

        ready_vec       = 2'b00;
        rom_type_c      = 2'd0;
        rom_addr_c      = 5'd0;
        fb_we_c         = 1'b0;
        fb_x_c          = '0;
        fb_y_c          = '0;
        fb_data_c       = '0;
        done_valid_c    = 1'b0;
        done_id_c       = 1'b0;
        done_err_c      = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_vec = grant;
                if (|grant) begin
                    type_next       = sel_type;
                    x_next          = req_x_arr[sel];
                    y_next          = req_y_arr[sel];
                    row_next        = 5'd0;
                    last_grant_next = sel;
                    id_next         = sel;
                    err_next        = !sel_is_note;
                    state_next      = sel_is_note ? DRAW : DONE;
                end
            end
            DRAW: begin
                // Everything below depends only on registered state, so a
                // stalled row presents identical fb_* values until accepted.
                rom_type_c = type_reg;
                rom_addr_c = row_reg;
                fb_we_c    = 1'b1;
                fb_x_c     = x_reg;
                fb_y_c     = y_reg + Y_W'(row_reg);  // wraps by design
                fb_data_c  = bus.rom_data;
                if (bus.fb_ready) begin
                    if (row_reg == LAST_ROW) begin
                        state_next = DONE;
                    end else begin
                        row_next = row_reg + 5'd1;
                    end
                end
            end
            DONE: begin
                done_valid_c = 1'b1;
                done_id_c    = id_reg;
                done_err_c   = err_reg;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Hold every output low while reset is asserted, whatever the state.
        if (!rst_n) begin
            ready_vec    = 2'b00;
            rom_type_c   = 2'd0;
            rom_addr_c   = 5'd0;
            fb_we_c      = 1'b0;
            fb_x_c       = '0;
            fb_y_c       = '0;
            fb_data_c    = '0;
            done_valid_c = 1'b0;
            done_id_c    = 1'b0;
            done_err_c   = 1'b0;
        end
    end

    assign bus.req0_ready = ready_vec[0];
    assign bus.req1_ready = ready_vec[1];
    assign bus.rom_type   = rom_type_c;
    assign bus.rom_addr   = rom_addr_c;
    assign bus.fb_we      = fb_we_c;
    assign bus.fb_x       = fb_x_c;
    assign bus.fb_y       = fb_y_c;
    assign bus.fb_data    = fb_data_c;
    assign bus.done_valid = done_valid_c;
    assign bus.done_id    = done_id_c;
    assign bus.done_err   = done_err_c;
endmodule

// File: tb/tb_note_draw_arbiter.sv
// tb_note_draw_arbiter
// Scoreboard bench for note_draw_arbiter. A request-level model predicts,
// for every accepted request, each framebuffer cycle (row data, x, y) from a
// pre-planned fb_ready schedule, plus the done pulse and its cycle. A
// separate monitor pops those expectations whenever the DUT writes or
// signals done.

`ifndef QUARTER_NOTE
`define QUARTER_NOTE 2'd0
`endif
`ifndef HALF_NOTE
`define HALF_NOTE 2'd1
`endif
`ifndef WHOLE_NOTE
`define WHOLE_NOTE 2'd2
`endif
`ifndef NOTE_WIDTH
`define NOTE_WIDTH 28
`endif

module tb_note_draw_arbiter;
    localparam int ROWS    = 24;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int NW      = `NOTE_WIDTH;
    localparam int SCHED_N = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit sched [SCHED_N];

    note_draw_arbiter_if #(.X_W(X_W), .Y_W(Y_W), .NOTE_WIDTH(NW)) bus ();

    note_draw_arbiter #(.ROWS(ROWS), .X_W(X_W), .Y_W(Y_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Requester drive state
    logic           v  [2];
    logic [1:0]     ty [2];
    logic [X_W-1:0] xx [2];
    logic [Y_W-1:0] yy [2];

    assign bus.req0_valid = v[0];
    assign bus.req0_type  = ty[0];
    assign bus.req0_x     = xx[0];
    assign bus.req0_y     = yy[0];
    assign bus.req1_valid = v[1];
    assign bus.req1_type  = ty[1];
    assign bus.req1_x     = xx[1];
    assign bus.req1_y     = yy[1];
    assign bus.fb_ready   = (cyc < SCHED_N) ? sched[cyc] : 1'b1;

    function automatic logic [NW-1:0] rom_fn(input logic [1:0] t, input logic [4:0] a);
        logic [31:0] h;
        h = (32'(t) * 32'd977 + 32'(a) * 32'd131 + 32'd7) * 32'h9E3779B1;
        return NW'(h >> 4);
    endfunction

    assign bus.rom_data = rom_fn(bus.rom_type, bus.rom_addr);

    typedef struct { int cyc; int x; int y; logic [NW-1:0] data; } wr_t;
    typedef struct { int cyc; int id; int err; } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    wr_t cur_w;
    dn_t cur_d;

    int tests    = 0;
    int fails    = 0;
    int idle_at  = 0;
    int last     = 1;
    int accepts  = 0;
    bit refill [2];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_note(input logic [1:0] t);
        return (t == `QUARTER_NOTE) || (t == `HALF_NOTE) || (t == `WHOLE_NOTE);
    endfunction

    function automatic bit rdy(input int c);
        return (c < SCHED_N) ? sched[c] : 1'b1;
    endfunction

    // Request-level model: what the draw of an accepted request looks like.
    task automatic predict(input int g);
        int t, r, c;
        t = cyc;
        last = g;
        accepts++;
        $display("[TB] cycle %0d accept req%0d type=%0d x=%0d y=%0d", t, g, ty[g], xx[g], yy[g]);
        if (is_note(ty[g])) begin
            r = 0;
            c = t + 1;
            while (r < ROWS) begin
                wq.push_back('{c, int'(xx[g]), (int'(yy[g]) + r) % (1 << Y_W),
                               rom_fn(ty[g], 5'(r))});
                if (rdy(c)) r++;
                c++;
            end
            dq.push_back('{c, g, 0});
            idle_at = c + 1;
        end else begin
            dq.push_back('{t + 1, g, 1});
            idle_at = t + 2;
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] t, input int x, input int y);
        v[i]  = 1'b1;
        ty[i] = t;
        xx[i] = X_W'(x);
        yy[i] = Y_W'(y);
    endtask

    task automatic rand_req(input int i);
        set_req(i, 2'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 511)));
    endtask

    // One cycle, entered just after a rising edge with this cycle's inputs set.
    task automatic step();
        int g;
        g = -1;
        if (cyc >= idle_at && (v[0] || v[1])) begin
            if (v[0] && v[1]) g = (last == 1) ? 0 : 1;
            else              g = v[0] ? 0 : 1;
            predict(g);
        end
        @(negedge clk);
        check("req0_ready", longint'(bus.req0_ready), longint'(g == 0));
        check("req1_ready", longint'(bus.req1_ready), longint'(g == 1));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            if (refill[g]) set_req(g, `QUARTER_NOTE, int'($urandom_range(0, 1023)),
                                   int'($urandom_range(0, 511)));
            else v[g] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((cyc < idle_at || v[0] || v[1]) && n < 400) begin
            step();
            n++;
        end
        check("idle_within_budget", longint'(n < 400), 1);
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        v[0] = 1'b0;
        v[1] = 1'b0;
        refill[0] = 1'b0;
        refill[1] = 1'b0;
        wq.delete();
        dq.delete();
        last = 1;
        repeat (ncyc) begin
            @(negedge clk);
            check("rst_fb_we",      longint'(bus.fb_we), 0);
            check("rst_done_valid", longint'(bus.done_valid), 0);
            check("rst_readys",     longint'({bus.req1_ready, bus.req0_ready}), 0);
            check("rst_rom_addr",   longint'(bus.rom_addr), 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle_at = cyc;
        @(negedge clk);
        check("post_rst_fb_we",      longint'(bus.fb_we), 0);
        check("post_rst_done_valid", longint'(bus.done_valid), 0);
        @(posedge clk);
        #1;
        $display("[TB] cycle %0d reset released", cyc);
    endtask

    // Monitor: pop expectations whenever the DUT writes or reports done.
    always @(negedge clk) begin
        if (rst_n) begin
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL fb_write_missing: got none, expected write at cycle %0d", wq[0].cyc);
                wq.delete(0);
            end
            if (bus.fb_we) begin
                if (wq.size() > 0 && wq[0].cyc == cyc) begin
                    cur_w = wq[0];
                    wq.delete(0);
                    check("fb_x",    longint'(bus.fb_x),    longint'(cur_w.x));
                    check("fb_y",    longint'(bus.fb_y),    longint'(cur_w.y));
                    check("fb_data", longint'(bus.fb_data), longint'(cur_w.data));
                end else begin
                    tests++;
                    fails++;
                    $display("FAIL fb_we_unexpected: got fb_we=1 at cycle %0d, expected 0", cyc);
                end
            end else begin
                check("rom_addr_idle", longint'(bus.rom_addr), 0);
                check("rom_type_idle", longint'(bus.rom_type), 0);
            end

            while (dq.size() > 0 && dq[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL done_missing: got none, expected done at cycle %0d", dq[0].cyc);
                dq.delete(0);
            end
            if (bus.done_valid) begin
                if (dq.size() > 0 && dq[0].cyc == cyc) begin
                    cur_d = dq[0];
                    dq.delete(0);
                    check("done_id",  longint'(bus.done_id),  longint'(cur_d.id));
                    check("done_err", longint'(bus.done_err), longint'(cur_d.err));
                    $display("[TB] cycle %0d done id=%0d err=%0d", cyc, bus.done_id, bus.done_err);
                end else begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: got done_valid=1 at cycle %0d, expected 0", cyc);
                end
            end
        end
    end

    initial begin
        int t, n;
        for (int c = 0; c < SCHED_N; c++) sched[c] = 1'b1;
        v[0] = 1'b0; v[1] = 1'b0;
        ty[0] = '0;  ty[1] = '0;
        xx[0] = '0;  xx[1] = '0;
        yy[0] = '0;  yy[1] = '0;
        refill[0] = 1'b0; refill[1] = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);

        // Contention from reset: both held valid; grants alternate 0,1,0,1.
        refill[0] = 1'b1;
        refill[1] = 1'b1;
        set_req(0, `QUARTER_NOTE, 10, 20);
        set_req(1, `QUARTER_NOTE, 30, 40);
        n = 0;
        while (accepts < 4 && n < 300) begin
            if (accepts == 3) begin
                refill[0] = 1'b0;
                refill[1] = 1'b0;
            end
            step();
            n++;
        end
        check("contention_accepts", longint'(accepts), 4);
        wait_idle();

        // Single quarter note.
        set_req(0, `QUARTER_NOTE, 100, 50);
        wait_idle();

        // Backpressure: fb_ready low two cycles on rows 0, 5 and 23.
        t = cyc;
        sched[t+1]  = 1'b0; sched[t+2]  = 1'b0;
        sched[t+8]  = 1'b0; sched[t+9]  = 1'b0;
        sched[t+28] = 1'b0; sched[t+29] = 1'b0;
        set_req(1, `HALF_NOTE, 321, 77);
        wait_idle();

        // Wraparound of fb_y.
        set_req(0, `WHOLE_NOTE, 37, 500);
        wait_idle();

        // Type matching no note.
        set_req(1, 2'd3, 5, 5);
        wait_idle();

        // Reset while drawing row 10, then both valid: grant must go to 0.
        set_req(0, `QUARTER_NOTE, 200, 100);
        repeat (11) step();
        do_reset(1);
        set_req(0, `QUARTER_NOTE, 1, 2);
        set_req(1, `HALF_NOTE, 3, 4);
        wait_idle();

        // Randomized traffic with random backpressure.
        for (int c = cyc + 1; c < SCHED_N; c++) sched[c] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && $urandom_range(0, 7) == 0) rand_req(i);
            end
            step();
        end
        wait_idle();
        repeat (3) step();
        check("write_queue_drained", longint'(wq.size()), 0);
        check("done_queue_drained",  longint'(dq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/note_draw_arbiter.md
# note_draw_arbiter

Sequencing controller for the note glyph ROM. Accepts note-draw requests from two requesters (0: score playback, 1: cursor/preview), arbitrates round-robin, and walks the glyph ROM row by row. Each 28-bit glyph row is streamed to the framebuffer write port with per-row backpressure. It sits between the score logic and the framebuffer and is the only block that drives the ROM address.

## Interface

Parameters:
- ROWS, 24, glyph height in rows; ROM addresses 0..ROWS-1.
- X_W, 10, framebuffer x coordinate width.
- Y_W, 9, framebuffer y coordinate width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req0_valid / req1_valid  in  1  draw request valid.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid && ready.
- req0_type / req1_type  in  2  note type; QUARTER_NOTE, HALF_NOTE, WHOLE_NOTE macros from constants.v.
- req0_x / req1_x  in  X_W  glyph left x.
- req0_y / req1_y  in  Y_W  glyph top y.
- rom_type  out  2  ROM note-type select.
- rom_addr  out  5  ROM row address.
- rom_data  in  NOTE_WIDTH  ROM row; combinational, valid in the same cycle.
- fb_we  out  1  framebuffer row write strobe.
- fb_x  out  X_W  row left x (captured x).
- fb_y  out  Y_W  captured y + row index.
- fb_data  out  NOTE_WIDTH  row bitmap; MSB is the leftmost pixel.
- fb_ready  in  1  framebuffer accepts the write this cycle.
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  1  requester that was served.
- done_err  out  1  with done_valid: the request type matched no note macro.

## Operation

- FSM states: IDLE, DRAW, DONE.
- **IDLE**
  - reqN_ready is high only for the granted requester. A requester is granted when it alone is valid, or when both are valid and it was not granted last.
  - last_grant resets to 1, so requester 0 wins the first contention.
  - On accept: capture type, x and y; set row=0 and last_grant=N.
  - If the type is a valid note: go to DRAW. Otherwise: go to DONE with err=1.
- **DRAW**
  - rom_type = captured type; rom_addr = row.
  - fb_we = 1; fb_data = rom_data; fb_x = captured x; fb_y = (y + row) mod 2^Y_W. There is no clipping; wraparound is intended.
  - When fb_ready: row increments. If row == ROWS-1, go to DONE instead.
  - When !fb_ready: all fb_* outputs hold stable and row holds.
- **DONE**
  - done_valid = 1 for one cycle, with done_id and done_err; then go to IDLE.
  - Both readys are low.
- Request inputs are ignored outside the accept cycle. Mid-draw input changes have no effect.
- Outside DRAW: fb_we = 0, rom_addr = 0, rom_type = 0.
- A pending request that loses arbitration stays pending and must hold valid. It is guaranteed service next. There is no starvation.
- A synchronous reset in any state does the following on the next edge:
  - state goes to IDLE; row and last_grant reset;
  - the in-flight draw is dropped with no done pulse;
  - fb_we is 0 in the cycle after the reset edge.

## Timing

- Reset values (while rst_n low, and on the first cycle after): all outputs 0, including both readys.
- Accept at cycle t. DRAW rows occupy cycles t+1..t+ROWS when fb_ready is held high. done_valid is at t+ROWS+1, and IDLE (ready possible again) is at t+ROWS+2.
- Each fb_ready-low cycle in DRAW adds exactly one cycle of latency.
- Invalid type: accept at t, done_valid with done_err at t+1, no fb_we.
- The ROM-to-fb_data path is combinational within one cycle. There is no pipeline register.
- Back-to-back requests: minimum spacing is ROWS+2 cycles.

## Test plan

- **Single quarter note:** req0 type QUARTER, x=100, y=50, fb_ready high. Expect 24 writes, fb_y 50..73, fb_x=100, fb_data equal to the ROM rows in order. Expect done_valid with done_id=0 at t+25.
- **Contention:** req0 and req1 both valid from reset. Grants go 0, 1, 0, 1 across four back-to-back requests, each spaced 26 cycles.
- **Backpressure:** HALF note with fb_ready low on rows 0, 5 and 23 (2 cycles each). fb_* outputs are stable while stalled. Exactly 24 write handshakes. done_valid arrives 6 cycles late.
- **Wraparound:** WHOLE note at y=500 with Y_W=9. fb_y sequence is 500..511, then 0..11.
- **Invalid type:** req1 type encoding matching no macro. No fb_we; done_valid=1, done_err=1, done_id=1 at t+1.
- **Reset mid-draw:** rst_n low for 1 cycle at row 10. fb_we=0 the cycle after the reset edge, no done pulse. A fresh req0 is accepted with grant to 0.
